transposer_arbiter: RTL and testbench

- Shares one Transposer tile engine (ELEMS x ELEMS elements of DATA_SIZE bits) between N_REQ requesters.
- Grants whole tiles round-robin, so the ELEMS input beats of a tile are never interleaved with another requester's beats.
- Tracks tile ownership in a small tag FIFO and routes each transposed output tile back to the requester that sent it.
- Sits between the NTT/ALU lane producers and the Transposer instance in the FHE interconnect.

---
 rtl/transposer_arbiter_pkg.sv | 13 +
 rtl/transposer_arbiter_tag_fifo.sv | 46 ++++
 rtl/transposer_arbiter.sv | 123 ++++++++++++
 tb/tb_transposer_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transposer_arbiter_pkg.sv
// Shared types and constants for the Transposer tile arbiter.
package transposer_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    STREAM = 1'b1
  } tp_arb_state_e;

  localparam int TP_N_REQ     = 4;
  localparam int TP_TAG_W     = $clog2(TP_N_REQ);
  localparam int TP_TAG_DEPTH = 2;

endpackage

// File: rtl/transposer_arbiter_tag_fifo.sv
// Two-entry tag FIFO: one tile draining out of the Transposer, one tile filling.
module tp_tag_fifo
  import transposer_arbiter_pkg::*;
#(
  parameter int TAG_W = TP_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [TAG_W-1:0] head
);

  logic [TAG_W-1:0] mem [TP_TAG_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TP_TAG_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/transposer_arbiter.sv
// Round-robin tile arbiter in front of a shared Transposer; tags each tile so the
// transposed output is routed back to the requester that sent it.
module transposer_arbiter
  import transposer_arbiter_pkg::*;
#(
  parameter int N_REQ     = TP_N_REQ,
  parameter int DATA_SIZE = 16,
  parameter int ELEMS     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ*DATA_SIZE*ELEMS-1:0]  req_data,
  output logic [N_REQ-1:0]                  req_ready,
  output logic [DATA_SIZE*ELEMS-1:0]        tp_in,
  output logic                              tp_in_valid,
  output logic                              tp_in_last,
  output logic                              tp_rstn,
  input  logic [DATA_SIZE*ELEMS-1:0]        tp_out,
  input  logic                              tp_out_valid,
  output logic [DATA_SIZE*ELEMS-1:0]        resp_data,
  output logic [N_REQ-1:0]                  resp_valid,
  output logic                              resp_last,
  output logic                              busy,
  output logic                              err
);

  localparam int BEAT_W = DATA_SIZE * ELEMS;
  localparam int TAG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [TAG_W-1:0] LAST_REQ  = TAG_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ELEMS - 1);

  tp_arb_state_e    state;
  logic [TAG_W-1:0] grant_id;
  logic [TAG_W-1:0] rr_ptr;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [TAG_W-1:0] pick_id;
  logic [TAG_W-1:0] cand;
  logic             pick_found;
  logic             stream;
  logic             tile_done;
  logic             out_fire;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TAG_W-1:0] fifo_head;

  // Walk from the farthest offset down so the requester nearest rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = TAG_W'((int'(rr_ptr) + i) % N_REQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign stream      = (state == STREAM);
  assign req_ready   = stream ? (N_REQ'(1) << grant_id) : '0;
  assign tp_in       = stream ? req_data[grant_id*BEAT_W +: BEAT_W] : '0;
  assign tp_in_valid = stream && req_valid[grant_id];
  assign tp_in_last  = 1'b0;
  assign tp_rstn     = ~rst;
  assign tile_done   = tp_in_valid && (in_cnt == LAST_BEAT);

  assign out_fire   = tp_out_valid && !fifo_empty;
  assign resp_data  = tp_out;
  assign resp_valid = out_fire ? (N_REQ'(1) << fifo_head) : '0;
  assign resp_last  = out_fire && (out_cnt == LAST_BEAT);
  assign busy       = stream || !fifo_empty;

  tp_tag_fifo #(.TAG_W(TAG_W)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tile_done),
    .push_tag (grant_id),
    .pop      (resp_last),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      grant_id <= '0;
      rr_ptr   <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (!fifo_full && pick_found) begin
            grant_id <= pick_id;
            rr_ptr   <= (pick_id == LAST_REQ) ? '0 : pick_id + 1'b1;
            state    <= STREAM;
          end
        end
        STREAM: begin
          // Grant is held through bubbles until the whole tile is in.
          if (tp_in_valid) begin
            if (tile_done) begin
              in_cnt <= '0;
              state  <= ARB;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        default: state <= ARB;
      endcase
      if (out_fire) out_cnt <= resp_last ? '0 : out_cnt + 1'b1;
      if (tp_out_valid && fifo_empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_transposer_arbiter.sv
// Directed bench for transposer_arbiter with a behavioural Transposer model.
module tb_transposer_arbiter;

  localparam int N_REQ     = 4;
  localparam int DATA_SIZE = 8;
  localparam int ELEMS     = 4;
  localparam int BEAT_W    = DATA_SIZE * ELEMS;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [N_REQ-1:0]          req_valid = '0;
  logic [N_REQ*BEAT_W-1:0]   req_data = '0;
  logic [N_REQ-1:0]          req_ready;
  logic [BEAT_W-1:0]         tp_in;
  logic                      tp_in_valid;
  logic                      tp_in_last;
  logic                      tp_rstn;
  logic [BEAT_W-1:0]         tp_out;
  logic                      tp_out_valid;
  logic [BEAT_W-1:0]         resp_data;
  logic [N_REQ-1:0]          resp_valid;
  logic                      resp_last;
  logic                      busy;
  logic                      err;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  transposer_arbiter #(.N_REQ(N_REQ), .DATA_SIZE(DATA_SIZE), .ELEMS(ELEMS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tp_in(tp_in), .tp_in_valid(tp_in_valid),
    .tp_in_last(tp_in_last), .tp_rstn(tp_rstn), .tp_out(tp_out),
    .tp_out_valid(tp_out_valid), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_last(resp_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Transposer model: captures ELEMS rows, loads one cycle later, drains columns.
  logic [BEAT_W-1:0]        mdl_out = '0;
  logic                     mdl_valid = 1'b0;
  logic [BEAT_W-1:0]        inj_data = '0;
  logic                     inj_valid = 1'b0;
  logic                     stall = 1'b0;
  logic [ELEMS*BEAT_W-1:0]  cur_tile = '0;
  logic [ELEMS*BEAT_W-1:0]  staged = '0;
  logic [ELEMS*BEAT_W-1:0]  tq[$];
  int                       row_cnt = 0;
  int                       col = 0;
  bit                       pending = 1'b0;

  assign tp_out       = inj_valid ? inj_data : mdl_out;
  assign tp_out_valid = mdl_valid | inj_valid;

  function automatic logic [BEAT_W-1:0] transpose_col(input logic [ELEMS*BEAT_W-1:0] tile, input int c);
    logic [BEAT_W-1:0] r;
    r = '0;
    for (int j = 0; j < ELEMS; j++)
      r[j*DATA_SIZE +: DATA_SIZE] = tile[j*BEAT_W + c*DATA_SIZE +: DATA_SIZE];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!tp_rstn) begin
      row_cnt = 0; col = 0; pending = 1'b0; tq.delete();
      mdl_valid <= 1'b0; mdl_out <= '0;
    end else begin
      if (!stall && tq.size() > 0) begin
        mdl_out   <= transpose_col(tq[0], col);
        mdl_valid <= 1'b1;
        if (col == ELEMS - 1) begin col = 0; void'(tq.pop_front()); end
        else col++;
      end else begin
        mdl_valid <= 1'b0;
      end
      if (pending) begin tq.push_back(staged); pending = 1'b0; end
      if (tp_in_valid) begin
        cur_tile[row_cnt*BEAT_W +: BEAT_W] = tp_in;
        if (row_cnt == ELEMS - 1) begin row_cnt = 0; pending = 1'b1; staged = cur_tile; end
        else row_cnt++;
      end
    end
  end

  // Expected column c of a tile whose row j holds base+4j .. base+4j+3.
  function automatic logic [BEAT_W-1:0] exp_col(input int base, input int c);
    logic [BEAT_W-1:0] r;
    r = '0;
    for (int j = 0; j < ELEMS; j++) r[j*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(base + ELEMS*j + c);
    return r;
  endfunction

  // Logs every response beat and every new grant (rising req_ready).
  typedef struct { logic [N_REQ-1:0] v; logic [BEAT_W-1:0] d; logic l; int cyc; } resp_t;
  typedef struct { int id; int cyc; } grant_t;
  resp_t  rq[$];
  grant_t gq[$];
  logic [N_REQ-1:0] prev_ready = '0;

  always @(negedge clk) begin
    #2;
    if (resp_valid != '0) rq.push_back('{resp_valid, resp_data, resp_last, cyc});
    if (req_ready != '0 && prev_ready == '0)
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gq.push_back('{i, cyc});
    prev_ready = req_ready;
  end

  task automatic set_row(input int r, input int base, input int b);
    for (int c = 0; c < ELEMS; c++)
      req_data[r*BEAT_W + c*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(base + ELEMS*b + c);
  endtask

  task automatic send_tile(input int r, input int base, input int gap_after, input int gap_len,
                           output int last_cyc);
    int  b = 0;
    int  t = 0;
    bit  fire;
    last_cyc = -1;
    set_row(r, base, 0);
    req_valid[r] = 1'b1;
    while (b < ELEMS && t < 200) begin
      #1 fire = req_ready[r] && req_valid[r];
      @(negedge clk);
      t++;
      if (fire) begin
        b++;
        last_cyc = cyc;
        if (b == gap_after && gap_len > 0) begin
          req_valid[r] = 1'b0;
          repeat (gap_len) @(negedge clk);
        end
        if (b < ELEMS) begin set_row(r, base, b); req_valid[r] = 1'b1; end
        else req_valid[r] = 1'b0;
      end
    end
    if (b < ELEMS) req_valid[r] = 1'b0;
  endtask

  task automatic wait_resp(input int n, output bit ok);
    int t = 0;
    while (rq.size() < n && t < 300) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    ok = (rq.size() >= n);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; stall = 1'b0; inj_valid = 1'b0;
    repeat (2) @(negedge clk);
    rq.delete(); gq.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req_valid = '1; req_data = '1; inj_valid = 1'b1; inj_data = 32'hA5A5_A5A5;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (req_ready !== 4'b0) begin failed++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    tests++; if (tp_in_valid !== 1'b0) begin failed++; $display("FAIL reset_tp_in_valid got %b exp 0", tp_in_valid); end
    tests++; if (tp_in !== 32'h0) begin failed++; $display("FAIL reset_tp_in got %h exp 0", tp_in); end
    tests++; if (tp_in_last !== 1'b0) begin failed++; $display("FAIL reset_tp_in_last got %b exp 0", tp_in_last); end
    tests++; if (resp_valid !== 4'b0) begin failed++; $display("FAIL reset_resp_valid got %b exp 0000", resp_valid); end
    tests++; if (resp_last !== 1'b0) begin failed++; $display("FAIL reset_resp_last got %b exp 0", resp_last); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (err !== 1'b0) begin failed++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if (tp_rstn !== 1'b0) begin failed++; $display("FAIL reset_tp_rstn got %b exp 0", tp_rstn); end
    inj_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    int lc;
    bit ok;
    do_reset();
    send_tile(2, 0, 0, 0, lc);
    wait_resp(4, ok);
    tests++; if (lc < 0) begin failed++; $display("FAIL single_accept got timeout exp 4 beats"); end
    tests++; if (!ok) begin failed++; $display("FAIL single_resp_count got %0d exp 4", rq.size()); end
    for (int k = 0; k < 4 && k < rq.size(); k++) begin
      tests++; if (rq[k].v !== 4'b0100) begin failed++; $display("FAIL single_owner beat %0d got %b exp 0100", k, rq[k].v); end
      tests++; if (rq[k].d !== exp_col(0, k)) begin failed++; $display("FAIL single_data beat %0d got %h exp %h", k, rq[k].d, exp_col(0, k)); end
      tests++; if (rq[k].l !== (k == 3)) begin failed++; $display("FAIL single_last beat %0d got %b exp %b", k, rq[k].l, k == 3); end
    end
    if (rq.size() > 0) begin
      tests++; if (rq[0].cyc - lc !== 2) begin failed++; $display("FAIL single_latency got %0d exp 2", rq[0].cyc - lc); end
    end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL single_busy_idle got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    int lc0, lc1, lc2, lc3, lc4;
    bit ok;
    int own[5]  = '{0, 1, 2, 3, 0};
    int base[5] = '{0, 16, 32, 48, 64};
    // Tile n+1 finishes one cycle before tile n's last beat pops its tag, so every
    // other grant waits one extra cycle on a full tag FIFO.
    int gap[4]  = '{5, 6, 5, 6};
    do_reset();
    fork
      begin send_tile(0, 0, 0, 0, lc0); send_tile(0, 64, 0, 0, lc4); end
      send_tile(1, 16, 0, 0, lc1);
      send_tile(2, 32, 0, 0, lc2);
      send_tile(3, 48, 0, 0, lc3);
    join
    wait_resp(20, ok);
    tests++; if (gq.size() !== 5) begin failed++; $display("FAIL rr_grant_count got %0d exp 5", gq.size()); end
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      tests++; if (gq[i].id !== own[i]) begin failed++; $display("FAIL rr_grant_order %0d got %0d exp %0d", i, gq[i].id, own[i]); end
    end
    for (int i = 0; i < 4 && i + 1 < gq.size(); i++) begin
      tests++; if (gq[i+1].cyc - gq[i].cyc !== gap[i]) begin failed++; $display("FAIL rr_grant_gap %0d got %0d exp %0d", i, gq[i+1].cyc - gq[i].cyc, gap[i]); end
    end
    tests++; if (!ok) begin failed++; $display("FAIL rr_resp_count got %0d exp 20", rq.size()); end
    for (int n = 0; n < 20 && n < rq.size(); n++) begin
      tests++; if (rq[n].v !== 4'(1 << own[n/4])) begin failed++; $display("FAIL rr_owner beat %0d got %b exp %b", n, rq[n].v, 4'(1 << own[n/4])); end
      tests++; if (rq[n].d !== exp_col(base[n/4], n%4)) begin failed++; $display("FAIL rr_data beat %0d got %h exp %h", n, rq[n].d, exp_col(base[n/4], n%4)); end
      tests++; if (rq[n].l !== (n%4 == 3)) begin failed++; $display("FAIL rr_last beat %0d got %b exp %b", n, rq[n].l, n%4 == 3); end
    end
  endtask

  task automatic test_drop();
    int lc1, lc3;
    int viol = 0;
    bit done1 = 1'b0;
    bit ok;
    do_reset();
    fork
      begin send_tile(1, 16, 2, 3, lc1); done1 = 1'b1; end
      send_tile(3, 48, 0, 0, lc3);
      begin
        int t = 0;
        while (!done1 && t < 200) begin @(negedge clk); #1; if (req_ready[3]) viol++; t++; end
      end
    join
    wait_resp(8, ok);
    tests++; if (viol !== 0) begin failed++; $display("FAIL drop_no_interleave got %0d ready cycles exp 0", viol); end
    tests++; if (gq.size() !== 2) begin failed++; $display("FAIL drop_grant_count got %0d exp 2", gq.size()); end
    if (gq.size() >= 2) begin
      tests++; if (gq[0].id !== 1 || gq[1].id !== 3) begin failed++; $display("FAIL drop_grant_order got %0d,%0d exp 1,3", gq[0].id, gq[1].id); end
      tests++; if (gq[1].cyc - gq[0].cyc !== 8) begin failed++; $display("FAIL drop_grant_hold got %0d exp 8", gq[1].cyc - gq[0].cyc); end
    end
    tests++; if (!ok) begin failed++; $display("FAIL drop_resp_count got %0d exp 8", rq.size()); end
    for (int n = 0; n < 8 && n < rq.size(); n++) begin
      tests++; if (rq[n].v !== (n < 4 ? 4'b0010 : 4'b1000)) begin failed++; $display("FAIL drop_owner beat %0d got %b", n, rq[n].v); end
      tests++; if (rq[n].d !== exp_col(n < 4 ? 16 : 48, n%4)) begin failed++; $display("FAIL drop_data beat %0d got %h exp %h", n, rq[n].d, exp_col(n < 4 ? 16 : 48, n%4)); end
    end
  endtask

  task automatic test_fifo_full();
    int lc0, lc1, lc2;
    int viol = 0;
    int bviol = 0;
    bit ok;
    do_reset();
    stall = 1'b1;
    send_tile(0, 0, 0, 0, lc0);
    send_tile(1, 16, 0, 0, lc1);
    fork
      send_tile(2, 32, 0, 0, lc2);
      begin
        repeat (6) begin @(negedge clk); #1; if (req_ready != '0) viol++; if (!busy) bviol++; end
        stall = 1'b0;
      end
    join
    wait_resp(12, ok);
    tests++; if (viol !== 0) begin failed++; $display("FAIL full_ready_held got %0d ready cycles exp 0", viol); end
    tests++; if (bviol !== 0) begin failed++; $display("FAIL full_busy got %0d idle cycles exp 0", bviol); end
    tests++; if (!ok) begin failed++; $display("FAIL full_resp_count got %0d exp 12", rq.size()); end
    tests++; if (gq.size() !== 3) begin failed++; $display("FAIL full_grant_count got %0d exp 3", gq.size()); end
    if (gq.size() >= 3 && rq.size() >= 12) begin
      tests++; if (gq[2].id !== 2) begin failed++; $display("FAIL full_grant_id got %0d exp 2", gq[2].id); end
      tests++; if (gq[2].cyc !== rq[3].cyc + 2) begin failed++; $display("FAIL full_grant_after_pop got %0d exp %0d", gq[2].cyc, rq[3].cyc + 2); end
      tests++; if (rq[3].l !== 1'b1) begin failed++; $display("FAIL full_first_last got %b exp 1", rq[3].l); end
      tests++; if (rq[0].v !== 4'b0001 || rq[4].v !== 4'b0010 || rq[8].v !== 4'b0100) begin
        failed++; $display("FAIL full_owners got %b %b %b exp 0001 0010 0100", rq[0].v, rq[4].v, rq[8].v); end
      tests++; if (rq[5].d !== exp_col(16, 1)) begin failed++; $display("FAIL full_data got %h exp %h", rq[5].d, exp_col(16, 1)); end
    end
  endtask

  task automatic test_reset_mid();
    int b = 0;
    int t = 0;
    int lc;
    bit fire;
    bit ok;
    do_reset();
    set_row(0, 0, 0);
    req_valid[0] = 1'b1;
    while (b < 2 && t < 20) begin
      #1 fire = req_ready[0] && req_valid[0];
      @(negedge clk); t++;
      if (fire) begin b++; set_row(0, 0, b); end
    end
    tests++; if (b !== 2) begin failed++; $display("FAIL mid_two_beats got %0d exp 2", b); end
    rst = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0) begin failed++; $display("FAIL mid_req_ready got %b exp 0000", req_ready); end
    tests++; if (tp_in_valid !== 1'b0) begin failed++; $display("FAIL mid_tp_in_valid got %b exp 0", tp_in_valid); end
    tests++; if (tp_rstn !== 1'b0) begin failed++; $display("FAIL mid_tp_rstn got %b exp 0", tp_rstn); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL mid_busy got %b exp 0", busy); end
    tests++; if (resp_valid !== 4'b0) begin failed++; $display("FAIL mid_resp_valid got %b exp 0000", resp_valid); end
    req_valid = '0;
    repeat (2) @(negedge clk);
    rq.delete(); gq.delete();
    rst = 1'b0;
    @(negedge clk);
    send_tile(0, 100, 0, 0, lc);
    wait_resp(4, ok);
    repeat (4) @(negedge clk);
    tests++; if (rq.size() !== 4) begin failed++; $display("FAIL mid_resp_count got %0d exp 4", rq.size()); end
    for (int k = 0; k < 4 && k < rq.size(); k++) begin
      tests++; if (rq[k].v !== 4'b0001 || rq[k].d !== exp_col(100, k) || rq[k].l !== (k == 3)) begin
        failed++; $display("FAIL mid_beat %0d got v=%b d=%h l=%b exp v=0001 d=%h", k, rq[k].v, rq[k].d, rq[k].l, exp_col(100, k)); end
    end
  endtask

  task automatic test_err();
    int lc;
    bit ok;
    do_reset();
    inj_data = 32'hDEAD_BEEF;
    inj_valid = 1'b1;
    #1;
    tests++; if (resp_valid !== 4'b0 || resp_last !== 1'b0) begin failed++; $display("FAIL err_drop got v=%b l=%b exp 0", resp_valid, resp_last); end
    @(negedge clk);
    inj_valid = 1'b0;
    #1;
    tests++; if (err !== 1'b1) begin failed++; $display("FAIL err_set got %b exp 1", err); end
    repeat (3) @(negedge clk);
    tests++; if (err !== 1'b1) begin failed++; $display("FAIL err_sticky got %b exp 1", err); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL err_busy got %b exp 0", busy); end
    tests++; if (rq.size() !== 0) begin failed++; $display("FAIL err_no_resp got %0d exp 0", rq.size()); end
    send_tile(3, 200, 0, 0, lc);
    wait_resp(4, ok);
    tests++; if (rq.size() !== 4) begin failed++; $display("FAIL err_after_count got %0d exp 4", rq.size()); end
    for (int k = 0; k < 4 && k < rq.size(); k++) begin
      tests++; if (rq[k].v !== 4'b1000 || rq[k].d !== exp_col(200, k) || rq[k].l !== (k == 3)) begin
        failed++; $display("FAIL err_after_beat %0d got v=%b d=%h l=%b exp v=1000 d=%h", k, rq[k].v, rq[k].d, rq[k].l, exp_col(200, k)); end
    end
    tests++; if (err !== 1'b1) begin failed++; $display("FAIL err_still_set got %b exp 1", err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_fifo_full();
    test_reset_mid();
    test_err();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
